bp_me_burst_to_lite_buffered: RTL and testbench

Converts a BedRock Burst stream (separate header and data channels, narrow data beats) into a BedRock Lite stream (one message carrying header and full-width data). It is the successor to the single-header burst-to-lite adapter and adds four things: a multi-entry header queue, a beat count derived from the header size field, replication of sub-width payloads, and protocol-error detection on the last-beat flag. It sits at wormhole/CCE/memory boundaries wherever a Burst producer feeds a Lite consumer.

---
 rtl/bp_me_burst_to_lite_buffered.sv | 114 +++++++++++
 tb/tb_bp_me_burst_to_lite_buffered.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_burst_to_lite_buffered.sv
// bp_me_burst_to_lite_buffered: queues Burst headers (hdr {payload,addr,size[2:0],msg_type[3:0]}), gathers narrow data beats and emits {header, replicated full-width data} Lite messages; error_o flags last-beat protocol violations
module bp_me_burst_to_lite_buffered #(
  parameter int paddr_width_p = 40,
  parameter int payload_width_p = 16,
  parameter int in_data_width_p = 64,
  parameter int out_data_width_p = 512,
  parameter logic [15:0] payload_mask_p = '0,
  parameter int header_els_p = 2,
  localparam int in_msg_header_width_lp = payload_width_p + paddr_width_p + 7,
  localparam int out_msg_width_lp = in_msg_header_width_lp + out_data_width_p
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [in_msg_header_width_lp-1:0] in_msg_header_i,
  input  logic                              in_msg_header_v_i,
  output logic                              in_msg_header_ready_and_o,
  input  logic [in_data_width_p-1:0]        in_msg_data_i,
  input  logic                              in_msg_data_v_i,
  output logic                              in_msg_data_ready_and_o,
  input  logic                              in_msg_last_i,
  output logic [out_msg_width_lp-1:0]       out_msg_o,
  output logic                              out_msg_v_o,
  input  logic                              out_msg_ready_and_i,
  output logic                              error_o
);
  localparam int ratio_lp = out_data_width_p / in_data_width_p;
  localparam int lg_ratio_lp = $clog2(ratio_lp);
  localparam int cnt_w_lp = lg_ratio_lp + 1;
  localparam int lg_inb_lp = $clog2(in_data_width_p / 8);
  localparam int lg_out_lp = $clog2(out_data_width_p);
  localparam int ptr_w_lp = header_els_p > 1 ? $clog2(header_els_p) : 1;
  localparam int cw_lp = $clog2(header_els_p + 1);
  localparam int hw_lp = in_msg_header_width_lp;

  if (out_data_width_p % in_data_width_p != 0 || header_els_p < 1) begin : g_bad_cfg
    $error("bp_me_burst_to_lite_buffered: illegal width ratio or header queue depth");
  end

  typedef enum logic [1:0] {e_idle, e_collect, e_ready} state_e;

  state_e state;
  logic [hw_lp-1:0] mem [header_els_p];
  logic [ptr_w_lp-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [cw_lp-1:0] count;
  logic [cnt_w_lp-1:0] cnt, beats;
  logic [out_data_width_p-1:0] data_r, data_rep;
  logic [lg_out_lp-1:0] rep_mask;
  logic [hw_lp-1:0] head, nxt_hdr;
  logic enq, deq, beat, last_beat, from_q, nxt_v;

  function automatic logic [ptr_w_lp-1:0] inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(header_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];
  assign rd_nxt = inc(rd_ptr);
  assign in_msg_header_ready_and_o = count != cw_lp'(header_els_p);
  assign in_msg_data_ready_and_o = state == e_collect;
  assign out_msg_v_o = state == e_ready;
  assign enq = in_msg_header_v_i & in_msg_header_ready_and_o;
  assign deq = out_msg_v_o & out_msg_ready_and_i;
  assign beat = in_msg_data_v_i & in_msg_data_ready_and_o;
  assign last_beat = cnt == beats - cnt_w_lp'(1);
  assign out_msg_o = {head, data_rep};

  // The header that decides the next state: one already queued behind the
  // current head, otherwise the header arriving this cycle (bypass keeps the
  // data-less latency at one cycle and avoids bubbles between messages).
  assign from_q = (state == e_idle) ? count != '0 : count > cw_lp'(1);
  assign nxt_hdr = from_q ? ((state == e_idle) ? head : mem[rd_nxt]) : in_msg_header_i;
  assign nxt_v = from_q | enq;

  always_comb begin
    beats = cnt_w_lp'(1);
    if (int'(head[6:4]) >= lg_inb_lp + lg_ratio_lp) beats = cnt_w_lp'(ratio_lp);
    else if (int'(head[6:4]) > lg_inb_lp) beats = cnt_w_lp'(1) << (int'(head[6:4]) - lg_inb_lp);
  end

  // Message width is a power of two, so replication is a masked bit index.
  assign rep_mask = (int'(head[6:4]) + 3 >= lg_out_lp) ? '1 : lg_out_lp'((1 << (int'(head[6:4]) + 3)) - 1);

  always_comb begin
    data_rep = data_r;
    for (int i = 0; i < out_data_width_p; i++) data_rep[i] = data_r[lg_out_lp'(i) & rep_mask];
  end

  always_ff @(posedge clk_i)
    if (enq) mem[wr_ptr] <= in_msg_header_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= e_idle;
      cnt <= '0;
      data_r <= '0;
      error_o <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= inc(wr_ptr);
      if (deq) rd_ptr <= rd_nxt;
      count <= count + cw_lp'(enq) - cw_lp'(deq);
      if (state == e_idle || deq) begin
        state <= nxt_v ? (payload_mask_p[nxt_hdr[3:0]] ? e_collect : e_ready) : e_idle;
        cnt <= '0;
      end else if (beat) begin
        data_r[int'(cnt) * in_data_width_p +: in_data_width_p] <= in_msg_data_i;
        cnt <= cnt + 1'b1;
        error_o <= error_o | (in_msg_last_i ^ last_beat);
        state <= (last_beat | in_msg_last_i) ? e_ready : e_collect;
      end
    end
  end
endmodule

// File: tb/tb_bp_me_burst_to_lite_buffered.sv
// tb_bp_me_burst_to_lite_buffered: randomized and directed self-checking bench against a queue-based message model
module tb_bp_me_burst_to_lite_buffered;
  localparam int HW = 63, OW = 512, IW = 64, MW = HW + OW;
  localparam logic [15:0] MASK = 16'h000C;

  logic clk = 0, rst = 1;
  logic [HW-1:0] hdr_i;
  logic hv = 0, h_ready;
  logic [IW-1:0] d_i;
  logic dv = 0, d_ready, d_last;
  logic [MW-1:0] out_msg;
  logic ov, oready, err;

  always #5 clk = ~clk;

  bp_me_burst_to_lite_buffered #(
    .paddr_width_p(40), .payload_width_p(16), .in_data_width_p(IW),
    .out_data_width_p(OW), .payload_mask_p(MASK), .header_els_p(2)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .in_msg_header_i(hdr_i), .in_msg_header_v_i(hv), .in_msg_header_ready_and_o(h_ready),
    .in_msg_data_i(d_i), .in_msg_data_v_i(dv), .in_msg_data_ready_and_o(d_ready),
    .in_msg_last_i(d_last),
    .out_msg_o(out_msg), .out_msg_v_o(ov), .out_msg_ready_and_i(oready),
    .error_o(err)
  );

  typedef struct { logic [IW-1:0] d; logic last; } beat_t;
  typedef struct { logic [HW-1:0] h; logic [OW-1:0] d; bit has; bit err; } exp_t;

  logic [HW-1:0] hq[$];
  beat_t dq[$];
  exp_t expq[$];
  logic [IW-1:0] slots [8];
  bit err_any = 0;
  int passed = 0, total = 0, cyc = 0, nbeats = 0, nhdrs = 0, last_h = 0, last_d = 0;
  int hs[$];
  logic [MW-1:0] last_out;
  int ready_mode = 1;
  bit thr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Builds one message from the size/type rules and queues its stimulus and expectation.
  // early: 0 none, -1 random early last, n>0 send n beats with last on the n-th.
  // pat: 0 random beats, 1 beat i carries i, 2 every beat carries d0.
  task automatic gen(input logic [3:0] t, input logic [2:0] sz, input int early, input bit miss,
                     input int pat, input logic [IW-1:0] d0);
    int bytes = 1 << sz;
    int nb = bytes / 8;
    int send;
    int bits;
    bit e = 0;
    bit has = MASK[t];
    logic [IW-1:0] val;
    logic [OW-1:0] s, x;
    logic [HW-1:0] h = {16'($urandom), 8'($urandom), 32'($urandom), sz, t};
    if (nb < 1) nb = 1;
    if (nb > 8) nb = 8;
    send = nb;
    if (has) begin
      if (early == -1 && nb > 1) begin send = $urandom_range(1, nb - 1); e = 1; end
      else if (early > 0 && early < nb) begin send = early; e = 1; end
      else if (miss) e = 1;
      for (int i = 0; i < send; i++) begin
        val = pat == 1 ? IW'(i) : pat == 2 ? d0 : {$urandom, $urandom};
        slots[i] = val;
        dq.push_back('{val, !miss && (i == send - 1)});
      end
    end
    err_any = err_any | e;
    for (int i = 0; i < 8; i++) s[i*IW +: IW] = slots[i];
    bits = bytes * 8 > OW ? OW : bytes * 8;
    for (int i = 0; i < OW; i++) x[i] = s[i % bits];
    hq.push_back(h);
    expq.push_back('{h, x, has, err_any});
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (expq.size() != 0 && n < 3000) begin @(negedge clk); #1; n++; end
    check({nm, "_drain"}, MW'(expq.size()), MW'(0));
  endtask

  task automatic rst_chk(input string nm);
    check({nm, "_hdr_ready"}, MW'(h_ready), MW'(1));
    check({nm, "_data_ready"}, MW'(d_ready), MW'(0));
    check({nm, "_out_v"}, MW'(ov), MW'(0));
    check({nm, "_error"}, MW'(err), MW'(0));
  endtask

  task automatic do_reset;
    @(posedge clk); #2 rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    hq.delete(); dq.delete(); expq.delete();
    for (int i = 0; i < 8; i++) slots[i] = '0;
    err_any = 0;
    @(negedge clk); #1;
  endtask

  // Stimulus driver for both input channels and the output ready.
  initial begin
    bit ha, da;
    forever begin
      @(negedge clk);
      ha = hv & h_ready & ~rst;
      da = dv & d_ready & ~rst;
      if (ha) begin last_h = cyc; nhdrs++; end
      if (da) begin last_d = cyc; nbeats++; end
      @(posedge clk); #1;
      if (rst) begin
        hq.delete(); dq.delete(); hv = 0; dv = 0;
      end else begin
        if (ha) void'(hq.pop_front());
        if (da) void'(dq.pop_front());
        if (!(hv && !ha)) hv = hq.size() != 0 && (!thr || $urandom_range(0, 3) != 0);
        if (hv) hdr_i = hq[0];
        if (!(dv && !da)) dv = dq.size() != 0 && (!thr || $urandom_range(0, 3) != 0);
        if (dv) begin d_i = dq[0].d; d_last = dq[0].last; end
      end
      oready = ready_mode == 2 ? 1'($urandom) : ready_mode == 1;
    end
  end

  // Compare process: every handshake against the model, every stalled cycle for hold.
  initial begin
    bit stall = 0;
    logic [MW-1:0] pmsg;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) stall = 0;
      else begin
        if (stall) begin
          check("hold_v", MW'(ov), MW'(1));
          check("hold_msg", out_msg, pmsg);
        end
        if (ov && oready) begin
          if (expq.size() == 0) begin
            total++;
            $display("FAIL spurious_msg: got %0h expected none", out_msg);
          end else begin
            e = expq.pop_front();
            check("hdr", MW'(out_msg[MW-1:OW]), MW'(e.h));
            if (e.has) check("data", MW'(out_msg[OW-1:0]), MW'(e.d));
            check("err", MW'(err), MW'(e.err));
          end
          hs.push_back(cyc);
          last_out = out_msg;
        end
        stall = ov & ~oready;
        pmsg = out_msg;
      end
    end
  end

  initial begin
    logic [OW-1:0] lit;
    int base, n;
    hdr_i = '0; d_i = '0; d_last = 0; oready = 1;
    for (int i = 0; i < 8; i++) slots[i] = '0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk); #1;
    rst_chk("reset");

    gen(4'd0, 3'd6, 0, 0, 0, '0);
    drain("t1");
    check("t1_latency", MW'(hs[hs.size()-1] - last_h), MW'(1));

    gen(4'd2, 3'd6, 0, 0, 1, '0);
    drain("t2");
    for (int i = 0; i < 8; i++) lit[i*IW +: IW] = IW'(i);
    check("t2_data", MW'(last_out[OW-1:0]), MW'(lit));
    check("t2_latency", MW'(hs[hs.size()-1] - last_d), MW'(1));

    gen(4'd3, 3'd2, 0, 0, 2, 64'hCAFE0000_DEADBEEF);
    drain("t3");
    check("t3_data", MW'(last_out[OW-1:0]), MW'({16{32'hDEADBEEF}}));

    ready_mode = 0;
    @(posedge clk); #2;
    base = nhdrs;
    gen(4'd0, 3'($urandom), 0, 0, 0, '0);
    gen(4'd1, 3'($urandom), 0, 0, 0, '0);
    gen(4'd0, 3'($urandom), 0, 0, 0, '0);
    n = 0;
    while (nhdrs < base + 2 && n < 100) begin @(negedge clk); #1; n++; end
    repeat (4) @(negedge clk);
    #1;
    check("t4_hdr_ready", MW'(h_ready), MW'(0));
    check("t4_out_v", MW'(ov), MW'(1));
    check("t4_head", MW'(out_msg[MW-1:OW]), MW'(expq[0].h));
    check("t4_third_waiting", MW'(hq.size()), MW'(1));
    ready_mode = 1;
    drain("t4");
    n = hs.size();
    check("t4_b2b_a", MW'(hs[n-2] - hs[n-3]), MW'(1));
    check("t4_b2b_b", MW'(hs[n-1] - hs[n-2]), MW'(1));

    gen(4'd2, 3'd6, 3, 0, 0, '0);
    gen(4'd0, 3'd6, 0, 0, 0, '0);
    drain("t5");
    check("t5_error_sticky", MW'(err), MW'(1));

    do_reset();
    rst_chk("reset2");

    ready_mode = 2;
    thr = 1;
    for (int i = 0; i < 40; i++)
      gen(4'($urandom_range(0, 3)), 3'($urandom), ($urandom_range(0, 19) == 0) ? -1 : 0,
          $urandom_range(0, 19) == 0, 0, '0);
    drain("random");

    do_reset();
    ready_mode = 1;
    thr = 0;
    gen(4'd2, 3'd6, 0, 0, 0, '0);
    base = nbeats;
    n = 0;
    while (nbeats < base + 4 && n < 100) begin @(negedge clk); #1; n++; end
    check("t6_four_beats", MW'(nbeats - base), MW'(4));
    do_reset();
    rst_chk("t6_reset");
    gen(4'd2, 3'd3, 0, 0, 2, 64'h0123_4567_89AB_CDEF);
    drain("t6");
    check("t6_data", MW'(last_out[OW-1:0]), MW'({8{64'h0123_4567_89AB_CDEF}}));
    check("t6_error", MW'(err), MW'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
